// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// assoc_cache : set-associative, write-back, write-allocate data cache with
//               first-invalid / round-robin replacement. Macro CACHE_STATS_EN
//               adds hit/miss/writeback counters.
// Revision    : 1.0
// ============================================================================
module assoc_cache #(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 6,
  parameter int WORD_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);

  localparam int c_sets     = 1 << SET_BITS;
  localparam int c_words    = 1 << WORD_BITS;
  localparam int c_tag_bits = 32 - SET_BITS - WORD_BITS - 2;
  localparam int c_way_bits = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WORD_BITS-1:0] c_last_beat = '1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  logic [31:0]           r_data  [WAYS][c_sets][c_words];
  logic [c_tag_bits-1:0] r_tags  [WAYS][c_sets];
  logic [c_sets-1:0]     r_valid [WAYS];
  logic [c_sets-1:0]     r_dirty [WAYS];

  logic [c_tag_bits-1:0] w_tag;
  logic [SET_BITS-1:0]   w_set;
  logic [WORD_BITS-1:0]  w_word;
  logic                  w_unused;

  state_t                r_state, w_state_nxt;
  logic [WORD_BITS-1:0]  r_beat, w_beat_nxt, w_beat_inc;
  logic [c_way_bits-1:0] r_vic;
  logic [SET_BITS-1:0]   r_set;
  logic [c_tag_bits-1:0] r_req_tag;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [31:0]           r_mem_addr, w_mem_addr_nxt;
  logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;

  logic                  w_hit;
  logic [c_way_bits-1:0] w_hit_way;
  logic [c_way_bits-1:0] w_vic;
  logic [c_way_bits-1:0] w_ptr;
  logic                  w_latch;
  logic                  w_fill_we;
  logic                  w_fill_done;
  logic                  w_store_hit;

  assign w_tag      = cpu_addr[31 -: c_tag_bits];
  assign w_set      = cpu_addr[2+WORD_BITS +: SET_BITS];
  assign w_word     = cpu_addr[2 +: WORD_BITS];
  assign w_unused   = &{1'b0, cpu_addr[1:0]};
  assign w_beat_inc = r_beat + 1'b1;

  // Hit search and victim choice; lowest-index invalid way overrides the pointer
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_vic     = w_ptr;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_set] && (r_tags[w][w_set] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_way_bits'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_set]) begin
        w_vic = c_way_bits'(w);
      end
    end
  end

  assign cpu_ready   = (r_state == S_IDLE) && cpu_req && w_hit;
  assign w_store_hit = cpu_ready && cpu_we;
  assign cpu_rdata   = cpu_ready ? r_data[w_hit_way][w_set][w_word] : 32'h0;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  generate
    if (WAYS > 1) begin : g_rr
      logic [c_way_bits-1:0] r_ptr [c_sets];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < c_sets; s++) begin
            r_ptr[s] <= '0;
          end
        end else if (w_fill_done) begin
          r_ptr[r_set] <= r_ptr[r_set] + 1'b1;
        end
      end
      assign w_ptr = r_ptr[w_set];
    end else begin : g_no_rr
      assign w_ptr = '0;
    end
  endgenerate

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_latch         = 1'b0;
    w_fill_we       = 1'b0;
    w_fill_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req && !w_hit) begin
          w_latch    = 1'b1;
          w_beat_nxt = '0;
          w_mem_req_nxt = 1'b1;
          if (r_valid[w_vic][w_set] && r_dirty[w_vic][w_set]) begin
            w_state_nxt     = S_WRITEBACK;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = {r_tags[w_vic][w_set], w_set, {WORD_BITS{1'b0}}, 2'b00};
            w_mem_wdata_nxt = r_data[w_vic][w_set][0];
          end else begin
            w_state_nxt    = S_REFILL;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = {w_tag, w_set, {WORD_BITS{1'b0}}, 2'b00};
          end
        end
      end
      S_WRITEBACK: begin
        if (r_mem_req && mem_ack) begin
          if (r_beat == c_last_beat) begin
            w_state_nxt   = S_REFILL;
            w_beat_nxt    = '0;
            w_mem_req_nxt = 1'b0;
            w_mem_we_nxt  = 1'b0;
          end else begin
            w_beat_nxt      = w_beat_inc;
            w_mem_addr_nxt  = {r_tags[r_vic][r_set], r_set, w_beat_inc, 2'b00};
            w_mem_wdata_nxt = r_data[r_vic][r_set][w_beat_inc];
          end
        end
      end
      S_REFILL: begin
        // Entered from writeback with mem_req low: launch the first refill beat
        if (!r_mem_req) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = {r_req_tag, r_set, r_beat, 2'b00};
        end else if (mem_ack) begin
          w_fill_we = 1'b1;
          if (r_beat == c_last_beat) begin
            w_fill_done   = 1'b1;
            w_state_nxt   = S_IDLE;
            w_beat_nxt    = '0;
            w_mem_req_nxt = 1'b0;
          end else begin
            w_beat_nxt     = w_beat_inc;
            w_mem_addr_nxt = {r_req_tag, r_set, w_beat_inc, 2'b00};
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_vic     <= w_vic;
      r_set     <= w_set;
      r_req_tag <= w_tag;
    end
  end

  // Line data and tags are never reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[r_vic][r_set][r_beat] <= mem_rdata;
    end else if (w_store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_be[b]) begin
          r_data[w_hit_way][w_set][w_word][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
    if (w_fill_done) begin
      r_tags[r_vic][r_set] <= r_req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      if (w_fill_done) begin
        r_valid[r_vic][r_set] <= 1'b1;
        r_dirty[r_vic][r_set] <= 1'b0;
      end
      if (w_store_hit) begin
        r_dirty[w_hit_way][w_set] <= 1'b1;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic r_post_refill;
  logic w_miss;
  logic w_wb_start;

  assign w_miss     = (r_state == S_IDLE) && cpu_req && !w_hit;
  assign w_wb_start = w_miss && (w_state_nxt == S_WRITEBACK);

  // The completion right after a refill is the tail of a miss, not a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_post_refill <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      wb_count      <= '0;
    end else begin
      r_post_refill <= w_fill_done;
      if (cpu_ready && !r_post_refill) hit_count <= hit_count + 32'd1;
      if (w_miss) miss_count <= miss_count + 32'd1;
      if (w_wb_start) wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// tb_assoc_cache : scoreboard bench for assoc_cache with a 2-cycle-ack memory
//                  model that returns data = address.
// Revision       : 1.0
// ============================================================================
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
`endif
  );

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        chk;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: ack the second cycle a beat is presented, data = address
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        cnt++;
        if (cnt == 2) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr;
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response or beat
  initial begin
    cpu_exp_t ce;
    mem_exp_t me;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_ready) begin
          if (cpu_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cpu_unexpected: actual ready with rdata=%h required no response", cpu_rdata);
          end else begin
            ce = cpu_q.pop_front();
            if (ce.chk) check("cpu_rdata", cpu_rdata, ce.data);
          end
        end
        if (mem_req && mem_ack) begin
          if (mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_unexpected: actual beat addr=%h we=%0d required no beat", mem_addr, mem_we);
          end else begin
            me = mem_q.pop_front();
            check("mem_we", {31'h0, mem_we}, {31'h0, me.we});
            check("mem_addr", mem_addr, me.addr);
            if (me.chk) check("mem_wdata", mem_wdata, me.wdata);
          end
        end
      end
    end
  end

  task automatic push_refill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) mem_q.push_back('{1'b0, base + 32'(4 * i), 1'b0, 32'h0});
  endtask

  task automatic push_wb(input logic [31:0] base, input int idx, input logic [31:0] val);
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = base + 32'(4 * i);
      mem_q.push_back('{1'b1, a, 1'b1, (i == idx) ? val : a});
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic chk, input logic [31:0] exp,
                        output int waited);
    cpu_q.push_back('{chk, exp});
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    cpu_req   = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!cpu_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!cpu_ready) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: actual no ready after %0d cycles addr=%h", waited, addr);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_be    = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold load, then repeat hit
    push_refill(32'h40);
    access(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h40, n);
    check("lat_miss_40", n, 9);
    access(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h40, n);
    check("lat_hit_40", n, 0);

    // Partial store hit and readback
    access(1'b1, 32'h44, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0, n);
    check("lat_store_hit", n, 0);
    access(1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 32'h0000BEEF, n);
    check("lat_hit_44", n, 0);

    // Set 4 conflicts: second way fills, third tag evicts dirty way 0
    push_refill(32'h440);
    access(1'b0, 32'h440, 32'h0, 4'h0, 1'b1, 32'h440, n);
    check("lat_miss_440", n, 9);
    push_wb(32'h40, 1, 32'h0000BEEF);
    push_refill(32'h840);
    access(1'b0, 32'h840, 32'h0, 4'h0, 1'b1, 32'h840, n);
    check("lat_dirty_840", n, 18);
    access(1'b0, 32'h440, 32'h0, 4'h0, 1'b1, 32'h440, n);
    check("lat_keep_440", n, 0);

    // Store miss allocates and merges, then gets written back on eviction
    push_refill(32'h1000);
    access(1'b1, 32'h1004, 32'hCAFEF00D, 4'b1100, 1'b0, 32'h0, n);
    check("lat_store_miss", n, 9);
    access(1'b0, 32'h1004, 32'h0, 4'h0, 1'b1, 32'hCAFE1004, n);
    check("lat_hit_1004", n, 0);
    push_refill(32'h1400);
    access(1'b0, 32'h1400, 32'h0, 4'h0, 1'b1, 32'h1400, n);
    check("lat_miss_1400", n, 9);
    push_wb(32'h1000, 1, 32'hCAFE1004);
    push_refill(32'h1800);
    access(1'b0, 32'h1800, 32'h0, 4'h0, 1'b1, 32'h1800, n);
    check("lat_dirty_1800", n, 18);

`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 32'd5);
    check("miss_count", miss_count, 32'd6);
    check("wb_count", wb_count, 32'd2);
`endif

    // Reset during the second refill beat aborts the transfer
    mem_q.push_back('{1'b0, 32'h2000, 1'b0, 32'h0});
    cpu_we   = 1'b0;
    cpu_addr = 32'h2000;
    cpu_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && mem_addr == 32'h2004) && n < 100);
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL abort_timeout: actual no second beat required beat at 00002004");
    end
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("abort_mem_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_refill(32'h2000);
    access(1'b0, 32'h2000, 32'h0, 4'h0, 1'b1, 32'h2000, n);
    check("lat_after_abort", n, 9);

    repeat (3) @(posedge clk);
    check("cpu_q_left", cpu_q.size(), 0);
    check("mem_q_left", mem_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/assoc_cache.md
# assoc_cache

Parametrised set-associative, write-back, write-allocate data cache for the MIPS core. It generalises the single-word direct-mapped cache to multi-word lines, configurable associativity and set count, and first-invalid/round-robin replacement. It sits between the MEM stage and main memory. CPU and memory sides use explicit ready/ack handshakes, so the pipeline stalls on misses instead of relying on fixed-count sequencing.

## Interface
- WAYS, 2, associativity; legal values 1, 2, 4
- SET_BITS, 6, log2 of the number of sets
- WORD_BITS, 2, log2 of the number of 32-bit words per line
- Derived: TAG_BITS = 32 - SET_BITS - WORD_BITS - 2; address = {tag, set, word, 2'b00}
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  access request; must stay high with stable address and data until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_be  in  4  byte enables for the store; bit i covers byte i
- cpu_rdata  out  32  load data; valid while cpu_ready
- cpu_ready  out  1  access completes this cycle (combinational)
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = writeback beat, 0 = refill beat
- mem_addr  out  32  word-aligned beat address
- mem_wdata  out  32  writeback data
- mem_rdata  in  32  refill data; valid with mem_ack
- mem_ack  in  1  beat accepted/completed; single-cycle pulse

## Operation
- Storage per set and way: valid, dirty, tag, and a line of 2^WORD_BITS words. Each set also holds a round-robin pointer of log2(WAYS) bits.
- FSM states:
  - IDLE: tag compare across all ways.
    - Hit: cpu_ready=1; cpu_rdata = selected word. A store writes the enabled bytes and sets dirty at the edge.
    - Miss with cpu_req: choose the victim, then go to WRITEBACK if the victim is valid and dirty, else REFILL.
  - WRITEBACK: issue 2^WORD_BITS beats, mem_we=1, mem_addr = {victim_tag, set, beat, 2'b00}. Advance the beat on each mem_ack. After the last ack, go to REFILL.
  - REFILL: issue beats 0..N-1, mem_we=0, mem_addr = {req_tag, set, beat, 2'b00}. Write mem_rdata into the victim line on each ack. On the last ack: valid=1, dirty=0, tag=req_tag, advance the set's round-robin pointer, go to IDLE.
  - IDLE after refill: the held request now hits. Stores merge at this point (write-allocate).
- Victim selection: the lowest-index invalid way. If every way is valid, use the set's round-robin pointer. Selection is latched when leaving IDLE.
- mem_req, mem_addr, mem_we and mem_wdata are registered. They stay stable until mem_ack. mem_req deasserts the cycle after the final ack of a phase.
- With WAYS=1 the block behaves as a direct-mapped cache and has no pointer.

## Timing
- Reset values: cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0 (don't-care while not ready). All valid, dirty and pointer bits cleared; state = IDLE. Data and tags are not cleared.
- Hit latency: 0 cycles (ready in the same cycle as cpu_req).
- Clean miss: mem_req rises 1 cycle after the miss and stays up through N acks. The block returns to IDLE the cycle after the last ack; ready follows in that same cycle.
- Dirty miss: N writeback acks, then N refill acks. There is no idle gap between phases beyond the 1-cycle mem_req drop.
- cpu_ready is never asserted outside IDLE.
- rst during WRITEBACK or REFILL aborts the transfer and invalidates all lines. mem_req=0 the cycle after reset. Memory must discard the partial transaction.
- A mem_ack while mem_req=0 is ignored.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_count, miss_count and wb_count, each 32 bits.
  - Cleared by rst; wrap modulo 2^32.
  - hit_count increments on each IDLE cycle with cpu_ready, excluding the post-refill completion.
  - miss_count increments on each IDLE to WRITEBACK/REFILL transition.
  - wb_count increments on entry to WRITEBACK.
- Not defined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
All scenarios use default parameters, with memory returning data = address and mem_ack 2 cycles after mem_req.
- Reset, then load 0x0000_0040 -> 4 refill beats at 0x40, 0x44, 0x48, 0x4C with mem_we=0. cpu_ready after the last ack with cpu_rdata=0x40. A repeat load gives ready in the same cycle.
- Store 0xDEADBEEF with be=4'b0011 to 0x44 (line resident) -> immediate ready. A load of 0x44 returns 0x0000BEEF, and no mem_req is issued.
- Loads of 0x040, 0x440 and 0x840 (all set 4) -> the third evicts way 0 via round-robin. The dirty line 0x40 is written back first: 4 mem_we=1 beats, mem_wdata at 0x44 = 0x0000BEEF. Refill of 0x840 follows.
- Store miss to 0x0000_1000 -> refill, then merge. The line is dirty, and a subsequent conflicting eviction writes back the merged word.
- rst asserted during the second refill beat -> mem_req=0 the next cycle. A load of the same address misses again.
- With CACHE_STATS_EN, after the scenario-3 sequence -> hit_count, miss_count = 3 and wb_count = 1 match the accesses issued.
